// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and multi-cycle stalls, branch flush, EX/MEM operand forwarding.
// Optional macro HAZ_FWD_EN enables forwarding; when undefined every in-flight producer match stalls instead.
module pipe_hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic [4:0] ex_wa,
  input  logic [4:0] mem_wa,
  input  logic       ex_wrf,
  input  logic       mem_wrf,
  input  logic       ex_load,
  input  logic [1:0] id_pcsource,
  input  logic       md_start,
  input  logic       md_done,
  output logic       stall_pc,
  output logic       stall_ifid,
  output logic       bubble_idex,
  output logic       flush_ifid,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic [1:0] hz_state
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_LDSTALL = 2'b01,
    ST_MDWAIT  = 2'b10,
    ST_BAD     = 2'b11
  } hz_state_e;

  hz_state_e state_q, state_d;
  logic      stall;
  logic      ld_hazard;

  // A used, nonzero source matching a producer that writes the register file.
  function automatic logic src_hit(input logic use_x, input logic [4:0] src,
                                   input logic wrf, input logic [4:0] wa);
    return use_x && (src != 5'd0) && wrf && (wa == src);
  endfunction

`ifdef HAZ_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic ex_wrf_i, input logic ex_load_i,
                                         input logic [4:0] ex_wa_i,
                                         input logic mem_wrf_i, input logic [4:0] mem_wa_i);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != 5'd0) begin
      if (ex_wrf_i && !ex_load_i && (ex_wa_i == src))
        sel = 2'b01;
      else if (mem_wrf_i && (mem_wa_i == src))
        sel = 2'b10;
    end
    return sel;
  endfunction

  // Only a load in EX cannot be forwarded in time.
  assign ld_hazard = ex_load & (src_hit(id_use_rs, id_rs, ex_wrf, ex_wa) |
                                src_hit(id_use_rt, id_rt, ex_wrf, ex_wa));
`else
  logic unused_ex_load;
  assign unused_ex_load = ex_load;

  assign ld_hazard = src_hit(id_use_rs, id_rs, ex_wrf,  ex_wa)  |
                     src_hit(id_use_rt, id_rt, ex_wrf,  ex_wa)  |
                     src_hit(id_use_rs, id_rs, mem_wrf, mem_wa) |
                     src_hit(id_use_rt, id_rt, mem_wrf, mem_wa);
`endif

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (ld_hazard) begin
          stall   = 1'b1;
          state_d = ST_LDSTALL;
        end else if (md_start) begin
          state_d = ST_MDWAIT;
        end
      end
      ST_LDSTALL: begin
`ifdef HAZ_FWD_EN
        state_d = ST_RUN;
`else
        if (ld_hazard)
          stall = 1'b1;
        else
          state_d = ST_RUN;
`endif
      end
      ST_MDWAIT: begin
        if (md_done)
          state_d = ST_RUN;
        else
          stall = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)
      state_q <= ST_RUN;
    else
      state_q <= state_d;
  end

  // Outputs are gated by reset so an in-progress stall is dropped immediately.
  always_comb begin
    stall_pc    = rst & stall;
    stall_ifid  = rst & stall;
    bubble_idex = rst & stall;
    flush_ifid  = rst & (id_pcsource != 2'b00) & ~stall;
    hz_state    = rst ? state_q : 2'b00;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
`ifdef HAZ_FWD_EN
    if (rst && !stall) begin
      fwd_a = fwd_sel(id_rs, ex_wrf, ex_load, ex_wa, mem_wrf, mem_wa);
      fwd_b = fwd_sel(id_rt, ex_wrf, ex_load, ex_wa, mem_wrf, mem_wa);
    end
`endif
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios, then random traffic checked
// against a rule-level model of stalls, flushes and forwarding (honours HAZ_FWD_EN like the design).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_wa, mem_wa;
  logic       id_use_rs, id_use_rt, ex_wrf, mem_wrf, ex_load, md_start, md_done;
  logic [1:0] id_pcsource;
  logic       stall_pc, stall_ifid, bubble_idex, flush_ifid;
  logic [1:0] fwd_a, fwd_b, hz_state;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] ex_wa;
    logic [4:0] mem_wa;
    logic       ex_wrf;
    logic       mem_wrf;
    logic       ex_load;
    logic [1:0] pcs;
    logic       md_start;
    logic       md_done;
  } stim_t;

  logic [10:0] exp_q[$];
  string       tag_q[$];

  // Model state: a multi-cycle op is outstanding / the previous cycle was a data-hazard stall.
  bit md_busy  = 1'b0;
  bit ld_after = 1'b0;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_wa(ex_wa), .mem_wa(mem_wa), .ex_wrf(ex_wrf), .mem_wrf(mem_wrf), .ex_load(ex_load),
    .id_pcsource(id_pcsource), .md_start(md_start), .md_done(md_done),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .bubble_idex(bubble_idex),
    .flush_ifid(flush_ifid), .fwd_a(fwd_a), .fwd_b(fwd_b), .hz_state(hz_state)
  );

  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic bit reads(input logic used, input logic [4:0] src,
                               input logic wr, input logic [4:0] dst);
    return used && (src != 0) && wr && (dst == src);
  endfunction

  function automatic logic [1:0] pick(input logic [4:0] src, input stim_t s);
    if (src == 0) return 2'd0;
    if (s.ex_wrf && !s.ex_load && s.ex_wa == src) return 2'd1;
    if (s.mem_wrf && s.mem_wa == src) return 2'd2;
    return 2'd0;
  endfunction

  // Apply one cycle of inputs, predict the outputs, then advance the model at the clock edge.
  task automatic step(input stim_t s, input string tag);
    logic [10:0] want;
    logic [1:0]  st, fa, fb;
    bit          ex_hit, mem_hit, hazard, stl, nmd, nld;
    rst = s.rst; id_rs = s.rs; id_rt = s.rt; id_use_rs = s.use_rs; id_use_rt = s.use_rt;
    ex_wa = s.ex_wa; mem_wa = s.mem_wa; ex_wrf = s.ex_wrf; mem_wrf = s.mem_wrf;
    ex_load = s.ex_load; id_pcsource = s.pcs; md_start = s.md_start; md_done = s.md_done;
    nmd = md_busy;
    nld = ld_after;
    if (!s.rst) begin
      want = '0;
      nmd  = 1'b0;
      nld  = 1'b0;
    end else begin
      st      = md_busy ? 2'd2 : (ld_after ? 2'd1 : 2'd0);
      ex_hit  = reads(s.use_rs, s.rs, s.ex_wrf, s.ex_wa) || reads(s.use_rt, s.rt, s.ex_wrf, s.ex_wa);
      mem_hit = reads(s.use_rs, s.rs, s.mem_wrf, s.mem_wa) || reads(s.use_rt, s.rt, s.mem_wrf, s.mem_wa);
`ifdef HAZ_FWD_EN
      hazard  = s.ex_load && ex_hit;
`else
      hazard  = ex_hit || mem_hit;
`endif
      stl = 1'b0;
      if (md_busy) begin
        stl = !s.md_done;
        nmd = !s.md_done;
      end else if (ld_after) begin
`ifdef HAZ_FWD_EN
        nld = 1'b0;
`else
        stl = hazard;
        nld = hazard;
`endif
      end else begin
        stl = hazard;
        nld = hazard;
        nmd = !hazard && s.md_start;
      end
      fa = 2'd0;
      fb = 2'd0;
`ifdef HAZ_FWD_EN
      if (!stl) begin
        fa = pick(s.rs, s);
        fb = pick(s.rt, s);
      end
`endif
      want = {stl, stl, stl, (s.pcs != 0) && !stl, fa, fb, st};
    end
    exp_q.push_back(want);
    tag_q.push_back(tag);
    @(posedge clk);
    md_busy  = nmd;
    ld_after = nld;
    #1;
  endtask

  // Monitor: compares the DUT outputs mid-cycle against the oldest queued expectation.
  initial begin
    logic [10:0] got, want;
    string       tag;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        tag  = tag_q.pop_front();
        got  = {stall_pc, stall_ifid, bubble_idex, flush_ifid, fwd_a, fwd_b, hz_state};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL %s t=%0t got=%b_%b_%b_%b_%b_%b_%b want=%b_%b_%b_%b_%b_%b_%b (pc,ifid,bub,flush,fa,fb,st)",
                   tag, $time, got[10], got[9], got[8], got[7], got[6:5], got[4:3], got[2:1] ,
                   want[10], want[9], want[8], want[7], want[6:5], want[4:3], want[2:1]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    stim_t s;
    s = idle(); s.rst = 1'b0;
    step(s, "idle_inputs_pre");
    @(posedge clk); #1;
    step(s, "reset_state");
    s.ex_wrf = 1; s.ex_load = 1; s.ex_wa = 5'd7; s.rs = 5'd7; s.use_rs = 1; s.pcs = 2'd2;
    step(s, "reset_gates_outputs");
    s = idle();
    step(s, "idle");

    // load in EX feeds rs; next cycle the load sits in MEM
    s = idle(); s.rs = 5; s.use_rs = 1; s.ex_wa = 5; s.ex_wrf = 1; s.ex_load = 1;
    step(s, "lw_use_stall");
    s.ex_wrf = 0; s.ex_load = 0; s.ex_wa = 0; s.mem_wa = 5; s.mem_wrf = 1;
    step(s, "lw_use_next");
    s = idle(); step(s, "lw_use_after");
    step(s, "lw_use_settle");

    // ALU producer of $3 in EX and an older one in MEM
    s = idle(); s.rt = 3; s.use_rt = 1; s.ex_wa = 3; s.ex_wrf = 1; s.mem_wa = 3; s.mem_wrf = 1;
    step(s, "ex_over_mem");
    s.ex_wrf = 0; s.ex_wa = 0;
    step(s, "mem_only");
    s = idle(); step(s, "alu_settle");
    step(s, "alu_settle2");

    // loads to $0 never stall or forward
    s = idle(); s.use_rs = 1; s.use_rt = 1; s.ex_wrf = 1; s.ex_load = 1; s.mem_wrf = 1;
    step(s, "lw_r0");

    // multi-cycle op, branch pending during the wait
    s = idle(); s.md_start = 1; step(s, "md_issue");
    s = idle(); s.pcs = 2'd1;
    repeat (4) step(s, "md_wait");
    s.md_done = 1; step(s, "md_done");
    s = idle(); step(s, "md_after");

    // load-use with a redirect in ID
    s = idle(); s.rs = 5; s.use_rs = 1; s.ex_wa = 5; s.ex_wrf = 1; s.ex_load = 1; s.pcs = 2'd1;
    step(s, "lu_branch_stall");
    s.ex_wrf = 0; s.ex_load = 0; s.ex_wa = 0; s.mem_wa = 5; s.mem_wrf = 1;
    step(s, "lu_branch_next");
    s.mem_wrf = 0; s.mem_wa = 0;
    step(s, "lu_branch_clear");
    s = idle(); step(s, "lu_branch_settle");

    // md_start together with a load-use hazard: the load-use stall wins
    s = idle(); s.rt = 9; s.use_rt = 1; s.ex_wa = 9; s.ex_wrf = 1; s.ex_load = 1; s.md_start = 1;
    step(s, "md_vs_lu");
    s = idle(); step(s, "md_vs_lu_next");
    step(s, "md_vs_lu_settle");

    // reset in the middle of MDWAIT and of LDSTALL
    s = idle(); s.md_start = 1; step(s, "rst_md_issue");
    s = idle(); step(s, "rst_md_wait1");
    s.rst = 0; step(s, "rst_md_wait2");
    s = idle(); step(s, "rst_md_after");
    s = idle(); s.rs = 4; s.use_rs = 1; s.ex_wa = 4; s.ex_wrf = 1; s.ex_load = 1;
    step(s, "rst_ld_stall");
    s = idle(); s.rst = 0; s.rs = 4; s.use_rs = 1; s.mem_wa = 4; s.mem_wrf = 1;
    step(s, "rst_ld_mid");
    s = idle(); step(s, "rst_ld_after");

    // random traffic with a small register set so matches are frequent
    for (int i = 0; i < 400; i++) begin
      s.rst      = ($urandom_range(0, 49) != 0);
      s.rs       = 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.use_rs   = 1'($urandom_range(0, 1));
      s.use_rt   = 1'($urandom_range(0, 1));
      s.ex_wa    = 5'($urandom_range(0, 3));
      s.mem_wa   = 5'($urandom_range(0, 3));
      s.ex_wrf   = 1'($urandom_range(0, 1));
      s.mem_wrf  = 1'($urandom_range(0, 1));
      s.ex_load  = 1'($urandom_range(0, 1));
      s.pcs      = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      s.md_start = ($urandom_range(0, 5) == 0);
      s.md_done  = ($urandom_range(0, 3) == 0);
      step(s, "random");
    end

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
